text_cursor_ctrl: RTL and testbench
===================================

# text_cursor_ctrl

Downstream consumer of the keyboard decode stage: turns its level-style outputs (`ascii_vec`, `nonchar_en`/`nonchar_key`, `stat`) into single key events. Maintains a cursor over a ROWS×COLS character screen, writes characters into the VGA text RAM and supports hardware scrolling through a top-row offset. It sits between the keyboard stage and the text-mode VGA renderer, which reads the RAM and consumes `top_row`, cursor position and visibility.

## Interface
- `COLS`, 70, characters per row
- `ROWS`, 30, rows on screen
- `COL_W`, 7, cursor column width
- `ROW_W`, 5, row index width
- `ADDR_W`, 12, text RAM address width (must satisfy ROWS*COLS ≤ 2^ADDR_W)
- `BLINK_DIV`, 25000000, clk cycles per cursor blink half-period
- `clk`  in  1  system clock
- `clr`  in  1  asynchronous active-high reset
- `ascii_vec`  in  8  ASCII of the held key; 0 = none
- `nonchar_en`  in  1  non-character key held
- `nonchar_key`  in  3  1 left, 2 down, 3 up, 4 right, 5 enter, 6 backspace
- `stat`  in  4  {alt, ctrl, shift, caps}
- `wr_en`  out  1  text RAM write strobe, one cycle per write
- `wr_addr`  out  ADDR_W  physical address = ((top_row+row) mod ROWS)*COLS + col
- `wr_data`  out  8  character to write
- `cur_row`  out  ROW_W  logical cursor row (0 = top of screen)
- `cur_col`  out  COL_W  cursor column
- `top_row`  out  ROW_W  physical RAM row shown at screen row 0
- `cur_vis`  out  1  cursor visible
- `busy`  out  1  high in INIT or CLRLINE

## Operation
- Event detect: registers `prev_ascii` and `prev_nc` ({nonchar_en, nonchar_key}) every cycle. A char event fires when `ascii_vec`≠0 and `ascii_vec`≠`prev_ascii`. A key event fires when `nonchar_en`=1 and `{nonchar_en, nonchar_key}`≠`prev_nc`. Held keys do not repeat. Char events are discarded while stat[2] or stat[3] is set.
- Pending slot: one entry. An event in a non-IDLE state is stored, overwriting any older pending event. IDLE services the pending entry before new input. If both event types fire in the same cycle, the key event wins.
- FSM states:
  - INIT: writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, then goes to IDLE.
  - IDLE: services events.
  - WRITE: one cycle with `wr_en`=1, then cursor update.
  - CLRLINE: writes 0x20 to the COLS cells of the new bottom physical row, then returns to IDLE.
- Printable char: WRITE at the cursor, then col+1. At col COLS-1 the cursor goes to col 0, row+1.
- Enter: col 0, row+1.
- Row overflow (row+1 = ROWS): row stays ROWS-1, `top_row` ← (top_row+1) mod ROWS, then CLRLINE.
- Backspace: moves the cursor left (col 0 → col COLS-1 of row-1), then WRITE 0x20 at the new position. At (0,0) it is a no-op.
- Left/right: move with the same wrap as typing. Right at (ROWS-1, COLS-1) clamps (no scroll). Left at (0,0) clamps.
- Up/down: clamp at 0 and ROWS-1, col unchanged.
- Reset: async; state goes to INIT. All outputs read 0 except `busy`=1, `wr_data`=0x20, `cur_vis`=1, and the pending slot is cleared. Reset mid-CLRLINE abandons the clear; INIT redoes the whole screen.

## Timing
- Event detected at cycle N (IDLE): `wr_en`=1 at N+1. Cursor/`top_row` update visible at N+2.
- Pure cursor move: cursor updated at N+1, no write.
- Enter on last row: `top_row` changes at N+1. CLRLINE `wr_en` runs N+1..N+COLS. `busy` falls at N+COLS+1.
- Char on last row/last col: WRITE at N+1, scroll at N+2, CLRLINE N+2..N+COLS+1.
- INIT: `wr_en` high for exactly ROWS*COLS consecutive cycles after reset release. `busy` low the cycle after.
- `wr_addr` and `wr_data` are valid only while `wr_en`=1. All outputs are registered.

## Configuration
- `CURSOR_BLINK_EN` defined: a counter toggles `cur_vis` every BLINK_DIV cycles. Any serviced event resets the counter and forces `cur_vis`=1.
- Undefined: `cur_vis` is constant 1 and there is no counter.

## Test plan
- Reset release -> exactly 2100 `wr_en` pulses with data 0x20 at addresses 0..2099. `busy` then 0, cursor (0,0), `top_row`=0.
- `ascii_vec` 0x61 held 1000 cycles, then 0, then 0x61 -> two writes of 0x61 at addr 0 and 1. Final cursor col=2.
- Cursor (29,5), enter -> `top_row`=1, cursor (29,0), 70 writes of 0x20 at addr 0..69.
- Cursor (3,0), backspace -> cursor (2,69), one write of 0x20 at addr 2*70+69=209. Backspace at (0,0) -> no write.
- During INIT: 0x41 then 0x42 -> only 0x42 written at addr 0 after INIT.
- stat=4'b0100 with 0x63 -> no write. Up at row 0 -> cursor unchanged.

Source files
------------

// File: rtl/text_cursor_ctrl_if.sv
// Keyboard-side inputs and text-RAM / renderer outputs of the text cursor controller.
interface text_cursor_ctrl_if #(
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 12
);
    logic [7:0]        ascii_vec;
    logic              nonchar_en;
    logic [2:0]        nonchar_key;
    logic [3:0]        stat;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  top_row;
    logic              cur_vis;
    logic              busy;

    modport master (
        output ascii_vec, nonchar_en, nonchar_key, stat,
        input  wr_en, wr_addr, wr_data, cur_row, cur_col, top_row, cur_vis, busy
    );

    modport slave (
        input  ascii_vec, nonchar_en, nonchar_key, stat,
        output wr_en, wr_addr, wr_data, cur_row, cur_col, top_row, cur_vis, busy
    );
endinterface

// File: rtl/text_cursor_ctrl.sv
// Turns held-key levels into single events, moves a text cursor and writes/scrolls the VGA text RAM.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module text_cursor_ctrl #(
    parameter int COLS      = 70,
    parameter int ROWS      = 30,
    parameter int COL_W     = 7,
    parameter int ROW_W     = 5,
    parameter int ADDR_W    = 12,
    parameter int BLINK_DIV = 25000000
) (
    input logic               clk,
    input logic               clr,
    text_cursor_ctrl_if.slave bus
);
    typedef enum logic [1:0] {INIT, IDLE, WRITE, CLRLINE} state_t;

    localparam logic [ROW_W:0]    ROWS_X    = (ROW_W+1)'(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS-1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS-1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS*COLS-1);
    localparam logic [7:0]        SPACE     = 8'h20;

    state_t            state_q;
    logic [7:0]        prevAscii_q;
    logic [3:0]        prevNc_q;
    logic              pendValid_q, pendIsKey_q;
    logic [7:0]        pendAscii_q;
    logic [2:0]        pendKey_q;
    logic [ROW_W-1:0]  row_q, top_q, nextRow_q;
    logic [COL_W-1:0]  col_q, nextCol_q, clrCnt_q;
    logic              scrollPend_q, wrEn_q, busy_q;
    logic [ADDR_W-1:0] wrAddr_q;
    logic [7:0]        wrData_q;

    logic              charEvt, keyEvt, newEvt, service;
    logic              atOrigin, atLastRow, atLastCol;
    logic              selIsKey, doWrite, doScroll;
    logic [7:0]        selAscii, wrChar;
    logic [2:0]        selKey;
    logic [ROW_W-1:0]  moveRow, retRow, topInc;
    logic [COL_W-1:0]  moveCol, retCol;
    logic [ADDR_W-1:0] wrAddrSel, clrBase;

    // The screen is a ring of physical rows; logical row 0 lives at physical row top_q.
    function automatic logic [ADDR_W-1:0] physAddr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c,
                                                   input logic [ROW_W-1:0] t);
        logic [ROW_W:0] sum;
        sum = {1'b0, r} + {1'b0, t};
        if (sum >= ROWS_X) sum = sum - ROWS_X;
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign charEvt   = (bus.ascii_vec != 8'h00) && (bus.ascii_vec != prevAscii_q)
                       && !(bus.stat[2] || bus.stat[3]);
    assign keyEvt    = bus.nonchar_en && ({bus.nonchar_en, bus.nonchar_key} != prevNc_q);
    assign newEvt    = charEvt || keyEvt;
    assign service   = (state_q == IDLE) && (pendValid_q || newEvt);
    assign atLastRow = (row_q == LAST_ROW);
    assign atLastCol = (col_q == LAST_COL);
    assign atOrigin  = (row_q == '0) && (col_q == '0);
    assign topInc    = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
    assign retRow    = (col_q == '0) ? row_q - 1'b1 : row_q;
    assign retCol    = (col_q == '0) ? LAST_COL : col_q - 1'b1;
    assign wrAddrSel = selIsKey ? physAddr(moveRow, moveCol, top_q) : physAddr(row_q, col_q, top_q);
    assign clrBase   = physAddr('0, '0, top_q);

    // Pending entry takes priority over fresh input; between fresh events a key beats a char.
    always_comb begin
        selIsKey = keyEvt;
        selAscii = bus.ascii_vec;
        selKey   = bus.nonchar_key;
        if (pendValid_q) begin
            selIsKey = pendIsKey_q;
            selAscii = pendAscii_q;
            selKey   = pendKey_q;
        end
        moveRow  = row_q;
        moveCol  = col_q;
        doWrite  = 1'b0;
        doScroll = 1'b0;
        wrChar   = selAscii;
        if (!selIsKey) begin
            doWrite = 1'b1;
            if (atLastCol) begin
                moveCol = '0;
                if (atLastRow) doScroll = 1'b1;
                else           moveRow  = row_q + 1'b1;
            end else begin
                moveCol = col_q + 1'b1;
            end
        end else begin
            case (selKey)
                3'd1: if (!atOrigin) begin
                    moveRow = retRow;
                    moveCol = retCol;
                end
                3'd2: if (!atLastRow) moveRow = row_q + 1'b1;
                3'd3: if (row_q != '0) moveRow = row_q - 1'b1;
                3'd4: if (!atLastCol) begin
                    moveCol = col_q + 1'b1;
                end else if (!atLastRow) begin
                    moveRow = row_q + 1'b1;
                    moveCol = '0;
                end
                3'd5: begin
                    moveCol = '0;
                    if (atLastRow) doScroll = 1'b1;
                    else           moveRow  = row_q + 1'b1;
                end
                3'd6: if (!atOrigin) begin
                    doWrite = 1'b1;
                    wrChar  = SPACE;
                    moveRow = retRow;
                    moveCol = retCol;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= INIT;
            prevAscii_q  <= '0;
            prevNc_q     <= '0;
            pendValid_q  <= 1'b0;
            pendIsKey_q  <= 1'b0;
            pendAscii_q  <= '0;
            pendKey_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            top_q        <= '0;
            nextRow_q    <= '0;
            nextCol_q    <= '0;
            clrCnt_q     <= '0;
            scrollPend_q <= 1'b0;
            wrEn_q       <= 1'b0;
            busy_q       <= 1'b1;
            wrAddr_q     <= '0;
            wrData_q     <= SPACE;
        end else begin
            prevAscii_q <= bus.ascii_vec;
            prevNc_q    <= {bus.nonchar_en, bus.nonchar_key};
            if (newEvt) begin
                pendIsKey_q <= keyEvt;
                pendAscii_q <= bus.ascii_vec;
                pendKey_q   <= bus.nonchar_key;
            end
            if (state_q != IDLE) begin
                if (newEvt) pendValid_q <= 1'b1;
            end else if (pendValid_q) begin
                pendValid_q <= newEvt;
            end

            case (state_q)
                INIT: begin
                    if (!wrEn_q) begin
                        wrEn_q   <= 1'b1;
                        wrAddr_q <= '0;
                    end else if (wrAddr_q == LAST_ADDR) begin
                        wrEn_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wrAddr_q <= wrAddr_q + 1'b1;
                    end
                end
                IDLE: if (service) begin
                    if (doWrite) begin
                        wrEn_q       <= 1'b1;
                        wrAddr_q     <= wrAddrSel;
                        wrData_q     <= wrChar;
                        nextRow_q    <= moveRow;
                        nextCol_q    <= moveCol;
                        scrollPend_q <= doScroll;
                        state_q      <= WRITE;
                    end else begin
                        row_q <= moveRow;
                        col_q <= moveCol;
                        if (doScroll) begin
                            top_q    <= topInc;
                            wrEn_q   <= 1'b1;
                            wrAddr_q <= clrBase;
                            wrData_q <= SPACE;
                            busy_q   <= 1'b1;
                            clrCnt_q <= '0;
                            state_q  <= CLRLINE;
                        end
                    end
                end
                WRITE: begin
                    wrEn_q  <= 1'b0;
                    row_q   <= nextRow_q;
                    col_q   <= nextCol_q;
                    state_q <= IDLE;
                    if (scrollPend_q) begin
                        top_q    <= topInc;
                        wrEn_q   <= 1'b1;
                        wrAddr_q <= clrBase;
                        wrData_q <= SPACE;
                        busy_q   <= 1'b1;
                        clrCnt_q <= '0;
                        state_q  <= CLRLINE;
                    end
                end
                CLRLINE: begin
                    if (clrCnt_q == LAST_COL) begin
                        wrEn_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        clrCnt_q <= clrCnt_q + 1'b1;
                        wrAddr_q <= wrAddr_q + 1'b1;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    logic [BLINK_W-1:0] blinkCnt_q;
    logic               curVis_q;

    // Typing or moving restarts the blink phase so the cursor is always shown right after activity.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            blinkCnt_q <= '0;
            curVis_q   <= 1'b1;
        end else if (service) begin
            blinkCnt_q <= '0;
            curVis_q   <= 1'b1;
        end else if (blinkCnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blinkCnt_q <= '0;
            curVis_q   <= ~curVis_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
        end
    end

    assign bus.cur_vis = curVis_q;
`else
    assign bus.cur_vis = 1'b1;
`endif

    assign bus.wr_en   = wrEn_q;
    assign bus.wr_addr = wrAddr_q;
    assign bus.wr_data = wrData_q;
    assign bus.cur_row = row_q;
    assign bus.cur_col = col_q;
    assign bus.top_row = top_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: expected RAM writes are queued as stimulus is applied and
// popped by a write monitor; cursor/scroll/busy timing is checked at fixed cycle offsets.
module tb_text_cursor_ctrl;
    localparam int CELLS = 2100;

    logic clk = 1'b0;
    logic clr;
    int   tests = 0;
    int   fails = 0;
    int   writeCnt = 0;
    logic [19:0] expQ[$];

    text_cursor_ctrl_if #(.COL_W(7), .ROW_W(5), .ADDR_W(12)) bus ();

    text_cursor_ctrl #(
        .COLS(70), .ROWS(30), .COL_W(7), .ROW_W(5), .ADDR_W(12), .BLINK_DIV(25000000)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic expectWrite(input int addr, input logic [7:0] data);
        expQ.push_back({12'(addr), data});
    endtask

    task automatic applyStimulus(input logic [7:0] ascii, input logic en, input logic [2:0] key,
                                 input logic [3:0] st, input int cycles);
        bus.ascii_vec   = ascii;
        bus.nonchar_en  = en;
        bus.nonchar_key = key;
        bus.stat        = st;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pressKey(input logic [2:0] key);
        applyStimulus(8'h00, 1'b1, key, 4'b0000, 2);
        applyStimulus(8'h00, 1'b0, 3'd0, 4'b0000, 2);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkCursor(input string tag, input int r, input int c);
        checkOutput({tag, "_row"}, 32'(bus.cur_row), 32'(r));
        checkOutput({tag, "_col"}, 32'(bus.cur_col), 32'(c));
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n = 0;
        while (bus.busy !== 1'b0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    // Every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [19:0] e;
        if (clr === 1'b0 && bus.wr_en === 1'b1) begin
            writeCnt++;
            tests++;
            assert (expQ.size() > 0) else begin
                fails++;
                $error("[TB] FAIL unexpected_write: observed addr %0d data %0h expected no write",
                       bus.wr_addr, bus.wr_data);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                tests++;
                assert ({bus.wr_addr, bus.wr_data} === e) else begin
                    fails++;
                    $error("[TB] FAIL write_data: observed addr %0d data %0h expected addr %0d data %0h",
                           bus.wr_addr, bus.wr_data, e[19:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        clr = 1'b1;
        bus.ascii_vec   = 8'h00;
        bus.nonchar_en  = 1'b0;
        bus.nonchar_key = 3'd0;
        bus.stat        = 4'b0000;
        #2;
        checkOutput("rst_busy", 32'(bus.busy), 32'd1);
        checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(bus.wr_data), 32'h20);
        checkOutput("rst_cur_vis", 32'(bus.cur_vis), 32'd1);
        checkOutput("rst_top", 32'(bus.top_row), 32'd0);
        checkCursor("rst_cursor", 0, 0);

        for (int a = 0; a < CELLS; a++) expectWrite(a, 8'h20);
        expectWrite(0, 8'h42);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Keys typed during INIT: only the newest survives in the pending slot.
        applyStimulus(8'h41, 1'b0, 3'd0, 4'b0000, 3);
        applyStimulus(8'h42, 1'b0, 3'd0, 4'b0000, 3);
        applyStimulus(8'h00, 1'b0, 3'd0, 4'b0000, 2);
        waitIdle("init", 2300);
        checkOutput("init_wr_count", 32'(writeCnt), 32'(CELLS));
        checkOutput("init_wr_en_off", 32'(bus.wr_en), 32'd0);
        checkOutput("init_top", 32'(bus.top_row), 32'd0);
        checkCursor("init_cursor", 0, 0);
        @(negedge clk);
        checkOutput("pend_wr_en", 32'(bus.wr_en), 32'd1);
        @(negedge clk);
        checkCursor("pend_cursor", 0, 1);

        expectWrite(1, 8'h61);
        expectWrite(2, 8'h61);
        applyStimulus(8'h61, 1'b0, 3'd0, 4'b0000, 1000);
        applyStimulus(8'h00, 1'b0, 3'd0, 4'b0000, 2);
        checkCursor("hold_cursor", 0, 2);
        bus.ascii_vec = 8'h61;
        @(negedge clk);
        checkOutput("chr_wr_en_n1", 32'(bus.wr_en), 32'd1);
        checkOutput("chr_col_n1", 32'(bus.cur_col), 32'd2);
        @(negedge clk);
        checkOutput("chr_wr_en_n2", 32'(bus.wr_en), 32'd0);
        checkOutput("chr_col_n2", 32'(bus.cur_col), 32'd3);
        applyStimulus(8'h00, 1'b0, 3'd0, 4'b0000, 2);

        applyStimulus(8'h63, 1'b0, 3'd0, 4'b0100, 3);
        applyStimulus(8'h00, 1'b0, 3'd0, 4'b0000, 2);
        checkCursor("ctrl_blocked", 0, 3);
        expectWrite(3, 8'h64);
        applyStimulus(8'h64, 1'b0, 3'd0, 4'b0001, 3);
        applyStimulus(8'h00, 1'b0, 3'd0, 4'b0000, 2);
        checkCursor("caps_allowed", 0, 4);

        pressKey(3'd3);
        checkCursor("up_clamp", 0, 4);
        for (int i = 0; i < 3; i++) pressKey(3'd2);
        for (int i = 0; i < 4; i++) pressKey(3'd1);
        checkCursor("move_3_0", 3, 0);
        expectWrite(209, 8'h20);
        pressKey(3'd6);
        checkCursor("bksp_wrap", 2, 69);
        pressKey(3'd3);
        pressKey(3'd3);
        checkCursor("up_twice", 0, 69);
        pressKey(3'd4);
        checkCursor("right_wrap", 1, 0);
        pressKey(3'd1);
        checkCursor("left_wrap", 0, 69);
        pressKey(3'd4);
        pressKey(3'd3);
        checkCursor("origin", 0, 0);
        pressKey(3'd6);
        checkCursor("bksp_origin", 0, 0);
        pressKey(3'd1);
        checkCursor("left_clamp", 0, 0);

        for (int i = 0; i < 31; i++) pressKey(3'd2);
        checkCursor("down_clamp", 29, 0);
        for (int i = 0; i < 5; i++) pressKey(3'd4);
        checkCursor("pos_29_5", 29, 5);

        // Enter on the last row scrolls immediately and clears the old top physical row.
        for (int c = 0; c < 70; c++) expectWrite(c, 8'h20);
        bus.nonchar_en  = 1'b1;
        bus.nonchar_key = 3'd5;
        @(negedge clk);
        checkOutput("ent_top_n1", 32'(bus.top_row), 32'd1);
        checkOutput("ent_busy_n1", 32'(bus.busy), 32'd1);
        checkCursor("ent_cursor_n1", 29, 0);
        bus.nonchar_en  = 1'b0;
        bus.nonchar_key = 3'd0;
        repeat (69) @(negedge clk);
        checkOutput("ent_busy_n70", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("ent_busy_n71", 32'(bus.busy), 32'd0);
        checkOutput("ent_wr_en_n71", 32'(bus.wr_en), 32'd0);

        pressKey(3'd1);
        pressKey(3'd2);
        checkCursor("pos_29_69", 29, 69);
        expectWrite(69, 8'h5A);
        for (int c = 70; c < 140; c++) expectWrite(c, 8'h20);
        bus.ascii_vec = 8'h5A;
        @(negedge clk);
        checkOutput("wrap_wr_en_n1", 32'(bus.wr_en), 32'd1);
        checkOutput("wrap_top_n1", 32'(bus.top_row), 32'd1);
        bus.ascii_vec = 8'h00;
        @(negedge clk);
        checkOutput("wrap_top_n2", 32'(bus.top_row), 32'd2);
        checkOutput("wrap_busy_n2", 32'(bus.busy), 32'd1);
        checkCursor("wrap_cursor_n2", 29, 0);
        waitIdle("wrap_clr", 100);

        pressKey(3'd1);
        pressKey(3'd2);
        pressKey(3'd4);
        checkCursor("right_clamp", 29, 69);
        checkOutput("right_clamp_top", 32'(bus.top_row), 32'd2);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("cur_vis_end", 32'(bus.cur_vis), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
